// File: rtl/mmu_cir_if.sv
// MC68851-style coprocessor-interface (CIR) slave: CPU-space decode, command FIFO,
// response/operand registers, abort/flush. Optional bus errors: define MMU_CIR_BERR_EN.
module mmu_cir_if #(
    parameter logic [2:0]  CPID        = 3'b000,
    parameter int          CMD_DEPTH   = 4,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] RESP_RST    = 16'h0802
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_dat_i,
    output logic [31:0] cpu_dat_o,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [2:0]  fc_i,
    output logic        ack_o,
    output logic        err_o,
    output logic        cmd_valid_o,
    output logic [15:0] cmd_o,
    input  logic        cmd_ready_i,
    input  logic        resp_we_i,
    input  logic [15:0] resp_i,
    output logic        opnd_valid_o,
    output logic [31:0] opnd_o,
    input  logic        opnd_ready_i,
    input  logic        opnd_we_i,
    input  logic [31:0] opnd_i,
    output logic        abort_o
);

`ifdef MMU_CIR_BERR_EN
    localparam bit BERR = 1'b1;
`else
    localparam bit BERR = 1'b0;
`endif

    localparam int         AW = (CMD_DEPTH > 2) ? $clog2(CMD_DEPTH) : 1;
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    wait_cnt_q, wait_cnt_d;
    logic [3:0]    stall_cnt_q, stall_cnt_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          abort_q, abort_d;
    logic [31:0]   dat_q, dat_d;
    logic [15:0]   resp_q, resp_d;
    logic [31:0]   opnd_q, opnd_d;
    logic          opnd_valid_q, opnd_valid_d;
    logic [31:0]   rb_q, rb_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]   cmd_mem [CMD_DEPTH];

    logic        cs;
    logic [3:0]  idx;
    logic        is_resp, is_ctrl, is_cmd, is_opnd;
    logic        bad_acc, berr_acc;
    logic        fifo_empty, fifo_full, cmd_pop;
    logic        cmd_stall, opnd_stall, stall, timeout;
    logic        finish, finish_err, finish_ok;
    logic        do_push, do_opnd_wr, do_flush;
    logic [31:0] rd_data;
    logic        unused_addr;

    assign unused_addr = ^{cpu_addr_i[31:20], cpu_addr_i[12:5], cpu_addr_i[0]};

    assign cs = cyc_i & stb_i & (fc_i == 3'b111) & (cpu_addr_i[19:16] == 4'b0010)
              & (cpu_addr_i[15:13] == CPID);
    assign idx     = cpu_addr_i[4:1];
    assign is_resp = (idx == 4'd0);
    assign is_ctrl = (idx == 4'd1);
    assign is_cmd  = (idx == 4'd5);
    assign is_opnd = (idx == 4'd8);

    // Wrong direction: writing the response CIR, reading control or command CIRs.
    assign bad_acc  = ~(is_resp | is_ctrl | is_cmd | is_opnd) | (is_resp & we_i)
                    | ((is_ctrl | is_cmd) & ~we_i);
    assign berr_acc = BERR & bad_acc;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_pop    = ~fifo_empty & cmd_ready_i;

    // A pop in the same cycle frees the slot, so a full FIFO does not stall then.
    assign cmd_stall  = is_cmd & we_i & fifo_full & ~cmd_pop;
    assign opnd_stall = is_opnd & we_i & opnd_valid_q & ~opnd_ready_i;
    assign stall      = cmd_stall | opnd_stall;
    assign timeout    = BERR & cmd_stall & (stall_cnt_q == 4'hF);

    assign finish     = (state_q == ST_WAIT) & cs & (wait_cnt_q == 3'd0) & (~stall | timeout);
    assign finish_err = finish & (berr_acc | timeout);
    assign finish_ok  = finish & ~finish_err;
    assign do_push    = finish_ok & is_cmd & we_i;
    assign do_opnd_wr = finish_ok & is_opnd & we_i;
    assign do_flush   = finish_ok & is_ctrl & we_i & cpu_dat_i[1];

    always_comb begin
        rd_data = 32'd0;
        if (is_resp)
            rd_data = {16'd0, resp_q};
        else if (is_opnd)
            rd_data = rb_q;
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cs) begin
                    state_d     = ST_WAIT;
                    wait_cnt_d  = WS;
                    stall_cnt_d = 4'd0;
                end
            end
            ST_WAIT: begin
                if (!cs)
                    state_d = ST_IDLE;
                else if (wait_cnt_q != 3'd0)
                    wait_cnt_d = wait_cnt_q - 3'd1;
                else if (finish)
                    state_d = ST_ACK;
                else if (stall_cnt_q != 4'hF)
                    stall_cnt_d = stall_cnt_q + 4'd1;
            end
            ST_ACK:  state_d = (cyc_i & stb_i) ? ST_DONE : ST_IDLE;
            ST_DONE: if (!(cyc_i & stb_i)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_d        = finish_ok;
        err_d        = finish_err;
        abort_d      = do_flush;
        dat_d        = (finish_ok & ~we_i) ? rd_data : dat_q;
        rb_d         = opnd_we_i ? opnd_i : rb_q;
        opnd_d       = do_opnd_wr ? cpu_dat_i : opnd_q;
        resp_d       = resp_q;
        opnd_valid_d = opnd_valid_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        // Flush wins over every concurrent push, pop and response load.
        if (do_flush) begin
            resp_d       = RESP_RST;
            opnd_valid_d = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
        end else begin
            if (resp_we_i)
                resp_d = resp_i;
            if (do_opnd_wr)
                opnd_valid_d = 1'b1;
            else if (opnd_valid_q & opnd_ready_i)
                opnd_valid_d = 1'b0;
            if (do_push)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (cmd_pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= 3'd0;
            stall_cnt_q  <= 4'd0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            abort_q      <= 1'b0;
            dat_q        <= 32'd0;
            resp_q       <= RESP_RST;
            opnd_q       <= 32'd0;
            opnd_valid_q <= 1'b0;
            rb_q         <= 32'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            abort_q      <= abort_d;
            dat_q        <= dat_d;
            resp_q       <= resp_d;
            opnd_q       <= opnd_d;
            opnd_valid_q <= opnd_valid_d;
            rb_q         <= rb_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push)
            cmd_mem[wr_ptr_q[AW-1:0]] <= cpu_dat_i[15:0];
    end

    assign cpu_dat_o    = dat_q;
    assign ack_o        = ack_q;
    assign err_o        = BERR ? err_q : 1'b0;
    assign abort_o      = abort_q;
    assign cmd_valid_o  = ~fifo_empty;
    assign cmd_o        = cmd_mem[rd_ptr_q[AW-1:0]];
    assign opnd_valid_o = opnd_valid_q;
    assign opnd_o       = opnd_q;

endmodule

// File: tb/tb_mmu_cir_if.sv
// Directed bench for mmu_cir_if with default parameters (CPID 0, depth 4, no wait states).
module tb_mmu_cir_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_dat_i = 32'd0;
    logic [31:0] cpu_dat_o;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [2:0]  fc = 3'd0;
    logic        ack_o, err_o;
    logic        cmd_valid_o;
    logic [15:0] cmd_o;
    logic        cmd_ready = 1'b0;
    logic        resp_we = 1'b0;
    logic [15:0] resp_i = 16'd0;
    logic        opnd_valid_o;
    logic [31:0] opnd_o;
    logic        opnd_ready = 1'b0;
    logic        opnd_we = 1'b0;
    logic [31:0] opnd_i = 32'd0;
    logic        abort_o;

    int          errors = 0;
    int          checks = 0;
    logic        acked, erred;
    int          lat;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    mmu_cir_if dut (
        .clk_i(clk), .rst_i(rst), .cpu_addr_i(cpu_addr), .cpu_dat_i(cpu_dat_i),
        .cpu_dat_o(cpu_dat_o), .cyc_i(cyc), .stb_i(stb), .we_i(we), .fc_i(fc),
        .ack_o(ack_o), .err_o(err_o), .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o),
        .cmd_ready_i(cmd_ready), .resp_we_i(resp_we), .resp_i(resp_i),
        .opnd_valid_o(opnd_valid_o), .opnd_o(opnd_o), .opnd_ready_i(opnd_ready),
        .opnd_we_i(opnd_we), .opnd_i(opnd_i), .abort_o(abort_o)
    );

    // One bus cycle; lat counts falling edges after the drive edge until ack/err or limit.
    task automatic bus_cycle(input logic wr, input logic [3:0] idx, input logic [31:0] wdata,
                             input logic [2:0] fcode, input logic [2:0] id, input int limit);
        @(negedge clk);
        cpu_addr  = {12'h000, 4'b0010, id, 8'h00, idx, 1'b0};
        cpu_dat_i = wdata;
        we = wr; fc = fcode; cyc = 1'b1; stb = 1'b1;
        acked = 1'b0; erred = 1'b0; lat = 0;
        while (lat < limit && !acked && !erred) begin
            @(negedge clk);
            lat++;
            if (ack_o) acked = 1'b1;
            if (err_o) erred = 1'b1;
        end
        rdata = cpu_dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("bus %s idx=%0d wdata=%h -> ack=%0b err=%0b lat=%0d rdata=%h",
                 wr ? "WR" : "RD", idx, wdata, acked, erred, lat, rdata);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ack_o !== 1'b0 || err_o !== 1'b0 || abort_o !== 1'b0) begin
            errors++; $display("FAIL reset_pulses ack=%b err=%b abort=%b want 0", ack_o, err_o, abort_o); end
        checks++; if (cpu_dat_o !== 32'd0) begin
            errors++; $display("FAIL reset_dat got %h want 0", cpu_dat_o); end
        checks++; if (cmd_valid_o !== 1'b0 || opnd_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid cmd=%b opnd=%b want 0", cmd_valid_o, opnd_valid_o); end
        bus_cycle(1'b0, 4'd0, 32'd0, 3'd7, 3'd0, 10);
        checks++; if (!acked || lat != 2) begin
            errors++; $display("FAIL resp_read_latency ack=%b lat=%0d want ack at 2", acked, lat); end
        checks++; if (rdata !== 32'h0000_0802) begin
            errors++; $display("FAIL resp_read_value got %h want 00000802", rdata); end
    endtask

    task automatic test_resp_update;
        fork
            bus_cycle(1'b0, 4'd0, 32'd0, 3'd7, 3'd0, 10);
            begin
                repeat (2) @(negedge clk);
                resp_we = 1'b1; resp_i = 16'h1234;
                @(negedge clk);
                resp_we = 1'b0;
            end
        join
        checks++; if (rdata !== 32'h0000_0802) begin
            errors++; $display("FAIL resp_same_cycle got %h want 00000802", rdata); end
        bus_cycle(1'b0, 4'd0, 32'd0, 3'd7, 3'd0, 10);
        checks++; if (rdata !== 32'h0000_1234) begin
            errors++; $display("FAIL resp_next_access got %h want 00001234", rdata); end
    endtask

    task automatic test_cmd_fifo;
        logic [15:0] exp;
        for (int k = 1; k <= 4; k++) begin
            bus_cycle(1'b1, 4'd5, 32'h0000_A000 + k, 3'd7, 3'd0, 10);
            checks++; if (!acked) begin
                errors++; $display("FAIL cmd_write_%0d ack=%b want 1", k, acked); end
        end
        checks++; if (cmd_valid_o !== 1'b1 || cmd_o !== 16'hA001) begin
            errors++; $display("FAIL cmd_head valid=%b cmd=%h want 1 A001", cmd_valid_o, cmd_o); end
        fork
            bus_cycle(1'b1, 4'd5, 32'h0000_A005, 3'd7, 3'd0, 20);
            begin
                repeat (6) @(negedge clk);
                cmd_ready = 1'b1;
                @(negedge clk);
                cmd_ready = 1'b0;
            end
        join
        checks++; if (!acked || lat != 6) begin
            errors++; $display("FAIL cmd_full_stall ack=%b lat=%0d want ack at 6", acked, lat); end
        cmd_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            exp = 16'hA000 + 16'(k);
            checks++; if (cmd_valid_o !== 1'b1 || cmd_o !== exp) begin
                errors++; $display("FAIL cmd_pop_order valid=%b cmd=%h want 1 %h", cmd_valid_o, cmd_o, exp); end
            @(negedge clk);
        end
        cmd_ready = 1'b0;
        checks++; if (cmd_valid_o !== 1'b0) begin
            errors++; $display("FAIL cmd_drained valid=%b want 0", cmd_valid_o); end
    endtask

    task automatic test_operand;
        bus_cycle(1'b1, 4'd8, 32'hDEAD_BEEF, 3'd7, 3'd0, 10);
        checks++; if (!acked || opnd_valid_o !== 1'b1 || opnd_o !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL opnd_write ack=%b valid=%b opnd=%h want 1 1 deadbeef", acked, opnd_valid_o, opnd_o); end
        fork
            bus_cycle(1'b1, 4'd8, 32'h1234_5678, 3'd7, 3'd0, 20);
            begin
                repeat (6) @(negedge clk);
                opnd_ready = 1'b1;
                @(negedge clk);
                opnd_ready = 1'b0;
            end
        join
        checks++; if (!acked || lat != 6) begin
            errors++; $display("FAIL opnd_stall ack=%b lat=%0d want ack at 6", acked, lat); end
        checks++; if (opnd_valid_o !== 1'b1 || opnd_o !== 32'h1234_5678) begin
            errors++; $display("FAIL opnd_second valid=%b opnd=%h want 1 12345678", opnd_valid_o, opnd_o); end
        opnd_ready = 1'b1;
        @(negedge clk);
        opnd_ready = 1'b0;
        checks++; if (opnd_valid_o !== 1'b0) begin
            errors++; $display("FAIL opnd_consume valid=%b want 0", opnd_valid_o); end
        opnd_we = 1'b1; opnd_i = 32'hCAFE_F00D;
        @(negedge clk);
        opnd_we = 1'b0;
        bus_cycle(1'b0, 4'd8, 32'd0, 3'd7, 3'd0, 10);
        checks++; if (rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL opnd_readback got %h want cafef00d", rdata); end
    endtask

    task automatic test_abort;
        for (int k = 1; k <= 3; k++)
            bus_cycle(1'b1, 4'd5, 32'h0000_B000 + k, 3'd7, 3'd0, 10);
        bus_cycle(1'b1, 4'd8, 32'h0000_5A5A, 3'd7, 3'd0, 10);
        checks++; if (cmd_valid_o !== 1'b1 || cmd_o !== 16'hB001 || opnd_valid_o !== 1'b1) begin
            errors++; $display("FAIL abort_setup cmd_valid=%b cmd=%h opnd_valid=%b", cmd_valid_o, cmd_o, opnd_valid_o); end
        bus_cycle(1'b1, 4'd1, 32'h0000_0002, 3'd7, 3'd0, 10);
        checks++; if (!acked || abort_o !== 1'b1) begin
            errors++; $display("FAIL abort_pulse ack=%b abort=%b want 1 1", acked, abort_o); end
        @(negedge clk);
        checks++; if (abort_o !== 1'b0 || cmd_valid_o !== 1'b0 || opnd_valid_o !== 1'b0) begin
            errors++; $display("FAIL abort_flush abort=%b cmd_valid=%b opnd_valid=%b want 0 0 0", abort_o, cmd_valid_o, opnd_valid_o); end
        bus_cycle(1'b0, 4'd0, 32'd0, 3'd7, 3'd0, 10);
        checks++; if (rdata !== 32'h0000_0802) begin
            errors++; $display("FAIL abort_resp got %h want 00000802", rdata); end
    endtask

    task automatic test_select;
        bus_cycle(1'b1, 4'd5, 32'h0000_EEEE, 3'd7, 3'b010, 6);
        checks++; if (acked || erred || cmd_valid_o !== 1'b0) begin
            errors++; $display("FAIL wrong_cpid ack=%b err=%b cmd_valid=%b want 0 0 0", acked, erred, cmd_valid_o); end
        bus_cycle(1'b1, 4'd5, 32'h0000_EEEE, 3'd5, 3'd0, 6);
        checks++; if (acked || erred || cmd_valid_o !== 1'b0) begin
            errors++; $display("FAIL wrong_fc ack=%b err=%b cmd_valid=%b want 0 0 0", acked, erred, cmd_valid_o); end
    endtask

    task automatic test_bad_access;
        bus_cycle(1'b1, 4'd0, 32'h0000_5555, 3'd7, 3'd0, 10);
`ifdef MMU_CIR_BERR_EN
        checks++; if (!erred || acked) begin
            errors++; $display("FAIL resp_write_berr err=%b ack=%b want 1 0", erred, acked); end
`else
        checks++; if (!acked || erred) begin
            errors++; $display("FAIL resp_write_ack ack=%b err=%b want 1 0", acked, erred); end
`endif
        bus_cycle(1'b0, 4'd0, 32'd0, 3'd7, 3'd0, 10);
        checks++; if (rdata !== 32'h0000_0802) begin
            errors++; $display("FAIL resp_write_ignored got %h want 00000802", rdata); end
        bus_cycle(1'b0, 4'd3, 32'd0, 3'd7, 3'd0, 10);
`ifdef MMU_CIR_BERR_EN
        checks++; if (!erred || acked) begin
            errors++; $display("FAIL unimpl_berr err=%b ack=%b want 1 0", erred, acked); end
`else
        checks++; if (!acked || rdata !== 32'd0) begin
            errors++; $display("FAIL unimpl_read ack=%b data=%h want 1 0", acked, rdata); end
`endif
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        cpu_addr = {12'h000, 4'b0010, 3'd0, 8'h00, 4'd0, 1'b0};
        we = 1'b0; fc = 3'd7; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ack_o !== 1'b0) begin
            errors++; $display("FAIL mid_reset_ack got %b want 0", ack_o); end
        cyc = 1'b0; stb = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++; if (ack_o !== 1'b0 || cpu_dat_o !== 32'd0) begin
            errors++; $display("FAIL mid_reset_after ack=%b dat=%h want 0 0", ack_o, cpu_dat_o); end
    endtask

    initial begin
        test_reset;
        test_resp_update;
        test_cmd_fifo;
        test_operand;
        test_abort;
        test_select;
        test_bad_access;
        test_mid_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
